pc_gen: RTL



---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage program-counter generator: state
// encoding, chip-enable levels and the active reset level.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_IDLE = 2'd0,
        PC_RUN  = 2'd1,
        PC_PEND = 2'd2
    } pc_state_e;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;
    localparam logic RstEnable   = 1'b1;

endpackage : pc_gen_pkg

// File: rtl/pc_gen.sv
// Program-counter generator with stall, parked branch redirect and flush.
// Optional macro PC_GEN_MISALIGN_CHK_EN adds the registered misalign_o flag.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 STEP     = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output logic              pend_o
`ifdef PC_GEN_MISALIGN_CHK_EN
    ,
    output logic              misalign_o
`endif
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ZERO_V = {ADDR_W{1'b0}};

    pc_state_e         state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pend_tgt_r;
    logic              ce_r;
    logic              pend_r;

    assign pc_o   = pc_r;
    assign ce_o   = ce_r;
    assign pend_o = pend_r;

`ifdef PC_GEN_MISALIGN_CHK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);

    logic misalign_r;
    assign misalign_o = misalign_r;

    function automatic logic misaligned_f(input logic [ADDR_W-1:0] addr);
        return |(addr & ALIGN_MASK);
    endfunction

    // Misalign flag follows every target load; increments clear it, holds keep it.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            misalign_r <= 1'b0;
        end else if (state_r == PC_RUN || state_r == PC_PEND) begin
            if (flush_i) begin
                misalign_r <= misaligned_f(flush_target_i);
            end else if (stall_i) begin
                misalign_r <= misalign_r;
            end else if (branch_i) begin
                misalign_r <= misaligned_f(branch_target_i);
            end else if (state_r == PC_PEND) begin
                misalign_r <= misaligned_f(pend_tgt_r);
            end else begin
                misalign_r <= 1'b0;
            end
        end else begin
            misalign_r <= 1'b0;
        end
    end
`endif

    // Fetch FSM and next-PC selection; flush outranks stall, stall outranks branch.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_r    <= PC_IDLE;
            pc_r       <= RESET_PC;
            pend_tgt_r <= ZERO_V;
            ce_r       <= ChipDisable;
            pend_r     <= 1'b0;
        end else begin
            case (state_r)
                PC_IDLE: begin
                    // First enabled fetch is RESET_PC itself, so the PC is not advanced here.
                    state_r <= PC_RUN;
                    ce_r    <= ChipEnable;
                    pend_r  <= 1'b0;
                end
                PC_RUN, PC_PEND: begin
                    ce_r <= ChipEnable;
                    if (flush_i) begin
                        pc_r       <= flush_target_i;
                        pend_tgt_r <= ZERO_V;
                        state_r    <= PC_RUN;
                        pend_r     <= 1'b0;
                    end else if (stall_i && branch_i) begin
                        pend_tgt_r <= branch_target_i;
                        state_r    <= PC_PEND;
                        pend_r     <= 1'b1;
                    end else if (stall_i) begin
                        pc_r <= pc_r;
                    end else if (branch_i) begin
                        pc_r       <= branch_target_i;
                        pend_tgt_r <= ZERO_V;
                        state_r    <= PC_RUN;
                        pend_r     <= 1'b0;
                    end else if (state_r == PC_PEND) begin
                        pc_r       <= pend_tgt_r;
                        pend_tgt_r <= ZERO_V;
                        state_r    <= PC_RUN;
                        pend_r     <= 1'b0;
                    end else begin
                        pc_r <= pc_r + STEP_V;
                    end
                end
                default: begin
                    state_r    <= PC_IDLE;
                    pc_r       <= RESET_PC;
                    pend_tgt_r <= ZERO_V;
                    ce_r       <= ChipDisable;
                    pend_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule : pc_gen
